raster_position_tracker: RTL and testbench

- Stream stage between the camera pixel source and downstream vision kernels.
- Accepts a ready/valid pixel stream and tags each pixel with column/row coordinates and start-of-frame, end-of-line and end-of-frame flags.
- Holds the result in a single-entry output pipeline register.
- Keeps a wrapping count of completed frames.

---
 rtl/vision_pkg.sv | 23 ++
 rtl/counter.sv | 26 ++
 rtl/raster_position_tracker.sv | 115 +++++++++++
 tb/tb_raster_position_tracker.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/vision_pkg.sv
// Shared frame geometry and pixel tag types for the vision stream stages.
package vision_pkg;

  localparam int unsigned DefaultFrameWidth  = 160;
  localparam int unsigned DefaultFrameHeight = 120;

  // Width of a coordinate that indexes 0..n-1; never narrower than one bit.
  function automatic int unsigned coord_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned DefaultXWidth = coord_width(DefaultFrameWidth);
  localparam int unsigned DefaultYWidth = coord_width(DefaultFrameHeight);

  typedef struct packed {
    logic [DefaultXWidth-1:0] x;
    logic [DefaultYWidth-1:0] y;
    logic                     sof;
    logic                     eol;
    logic                     eof;
  } pixel_tag_t;

endpackage

// File: rtl/counter.sv
// Generic up/down counter with synchronous active-high reset; wraps at both ends.
module counter #(
  parameter int unsigned width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               up_i,
  input  logic               down_i,
  output logic [width_p-1:0] count_o
);

  logic [width_p-1:0] r_count;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_count <= '0;
    end else if (up_i && !down_i) begin
      r_count <= r_count + width_p'(1);
    end else if (down_i && !up_i) begin
      r_count <= r_count - width_p'(1);
    end
  end

  assign count_o = r_count;

endmodule

// File: rtl/raster_position_tracker.sv
// Tags a ready/valid pixel stream with raster coordinates and frame flags,
// holding the result in a single-entry output register.
module raster_position_tracker
  import vision_pkg::*;
#(
  parameter int unsigned width_p             = 8,
  parameter int unsigned frame_width_p       = DefaultFrameWidth,
  parameter int unsigned frame_height_p      = DefaultFrameHeight,
  parameter int unsigned frame_count_width_p = 8
) (
  input  logic                                     clk_i,
  input  logic                                     reset_i,
  input  logic                                     resync_i,
  input  logic                                     valid_i,
  input  logic [width_p-1:0]                       data_i,
  output logic                                     ready_o,
  output logic                                     valid_o,
  output logic [width_p-1:0]                       data_o,
  output logic [coord_width(frame_width_p)-1:0]    x_o,
  output logic [coord_width(frame_height_p)-1:0]   y_o,
  output logic                                     sof_o,
  output logic                                     eol_o,
  output logic                                     eof_o,
  input  logic                                     ready_i,
  output logic [frame_count_width_p-1:0]           frame_count_o
);

  localparam int unsigned XW = coord_width(frame_width_p);
  localparam int unsigned YW = coord_width(frame_height_p);
  localparam logic [XW-1:0] XLast = XW'(frame_width_p - 1);
  localparam logic [YW-1:0] YLast = YW'(frame_height_p - 1);

  logic [XW-1:0]      r_xn, r_x;
  logic [YW-1:0]      r_yn, r_y;
  logic               r_valid, r_sof, r_eol, r_eof;
  logic [width_p-1:0] r_data;

  logic          w_accept, w_send;
  logic [XW-1:0] w_xc;
  logic [YW-1:0] w_yc;
  logic          w_sof, w_eol, w_eof;

  // Reset forces ready high but blocks the accept so nothing is committed.
  assign ready_o  = reset_i | ~r_valid | ready_i;
  assign w_accept = valid_i & ready_o & ~reset_i;
  assign w_send   = r_valid & ready_i;

  always_comb begin
    w_xc  = resync_i ? '0 : r_xn;
    w_yc  = resync_i ? '0 : r_yn;
    w_sof = (w_xc == '0) && (w_yc == '0);
    w_eol = (w_xc == XLast);
    w_eof = w_eol && (w_yc == YLast);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_sof   <= 1'b0;
      r_eol   <= 1'b0;
      r_eof   <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_data  <= data_i;
      r_x     <= w_xc;
      r_y     <= w_yc;
      r_sof   <= w_sof;
      r_eol   <= w_eol;
      r_eof   <= w_eof;
    end else if (w_send) begin
      r_valid <= 1'b0;
    end
  end

  // Next-coordinate counters: wrap to zero at line and frame ends.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_xn <= '0;
      r_yn <= '0;
    end else if (w_accept) begin
      if (w_eol) begin
        r_xn <= '0;
        r_yn <= w_eof ? '0 : w_yc + YW'(1);
      end else begin
        r_xn <= w_xc + XW'(1);
        r_yn <= w_yc;
      end
    end else if (resync_i) begin
      r_xn <= '0;
      r_yn <= '0;
    end
  end

  counter #(
    .width_p (frame_count_width_p)
  ) u_frame_counter (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .up_i    (w_accept & w_eof),
    .down_i  (1'b0),
    .count_o (frame_count_o)
  );

  assign valid_o = r_valid;
  assign data_o  = r_data;
  assign x_o     = r_x;
  assign y_o     = r_y;
  assign sof_o   = r_sof;
  assign eol_o   = r_eol;
  assign eof_o   = r_eof;

endmodule

// File: tb/tb_raster_position_tracker.sv
// Directed and random bench for raster_position_tracker on a 4x3 frame with a
// 2-bit frame counter, checked against a linear-pixel-index reference model.
module tb_raster_position_tracker;

  localparam int unsigned W   = 4;
  localparam int unsigned H   = 3;
  localparam int unsigned FCW = 2;

  typedef struct {
    logic [7:0] d;
    int         x;
    int         y;
    bit         sof;
    bit         eol;
    bit         eof;
  } tag_t;

  logic       clk = 1'b0;
  logic       reset_i, resync_i, valid_i, ready_i;
  logic [7:0] data_i;
  logic       ready_o, valid_o, sof_o, eol_o, eof_o;
  logic [7:0] data_o;
  logic [1:0] x_o, y_o;
  logic [FCW-1:0] frame_count_o;

  raster_position_tracker #(
    .width_p             (8),
    .frame_width_p       (W),
    .frame_height_p      (H),
    .frame_count_width_p (FCW)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .resync_i      (resync_i),
    .valid_i       (valid_i),
    .data_i        (data_i),
    .ready_o       (ready_o),
    .valid_o       (valid_o),
    .data_o        (data_o),
    .x_o           (x_o),
    .y_o           (y_o),
    .sof_o         (sof_o),
    .eol_o         (eol_o),
    .eof_o         (eof_o),
    .ready_i       (ready_i),
    .frame_count_o (frame_count_o)
  );

  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  tag_t q[$];     // pixels accepted but not yet sent
  int   p  = 0;   // linear index of the next pixel within its frame
  int   fc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic tag_t mk(input int idx, input logic [7:0] d);
    tag_t t;
    t.d   = d;
    t.x   = idx % W;
    t.y   = idx / W;
    t.sof = (idx == 0);
    t.eol = (idx % W) == W - 1;
    t.eof = (idx == W * H - 1);
    return t;
  endfunction

  // Check outputs at negedge, then advance the model at the following posedge.
  task automatic cycle();
    bit exp_ready, acc, snd;
    @(negedge clk);
    exp_ready = reset_i || (q.size() == 0) || ready_i;
    chk("ready_o", ready_o, exp_ready);
    chk("valid_o", valid_o, q.size() != 0);
    chk("frame_count", frame_count_o, fc);
    if (q.size() != 0) begin
      chk("data_o", data_o, q[0].d);
      chk("x_o", x_o, q[0].x);
      chk("y_o", y_o, q[0].y);
      chk("sof_o", sof_o, q[0].sof);
      chk("eol_o", eol_o, q[0].eol);
      chk("eof_o", eof_o, q[0].eof);
    end
    acc = valid_i && exp_ready && !reset_i;
    snd = (q.size() != 0) && ready_i;
    @(posedge clk);
    if (reset_i) begin
      q.delete();
      p  = 0;
      fc = 0;
    end else begin
      if (snd) void'(q.pop_front());
      if (acc) begin
        if (resync_i) p = 0;
        q.push_back(mk(p, data_i));
        if (p == W * H - 1) begin
          p  = 0;
          fc = (fc + 1) % (1 << FCW);
        end else begin
          p++;
        end
      end else if (resync_i) begin
        p = 0;
      end
    end
    #1;
  endtask

  task automatic px(input bit v, input logic [7:0] d, input bit rdy, input bit rs);
    reset_i  = 1'b0;
    valid_i  = v;
    data_i   = d;
    ready_i  = rdy;
    resync_i = rs;
    cycle();
  endtask

  task automatic do_reset();
    reset_i  = 1'b1;
    valid_i  = 1'b0;
    resync_i = 1'b0;
    ready_i  = 1'b1;
    cycle();
  endtask

  initial begin
    int fc_before;
    int fseq[5];
    fseq = '{1, 2, 3, 0, 1};
    reset_i  = 1'b1;
    resync_i = 1'b0;
    valid_i  = 1'b0;
    ready_i  = 1'b1;
    data_i   = 8'h00;
    @(posedge clk);
    #1;
    do_reset();
    chk("rst_data", data_o, 0);
    chk("rst_x", x_o, 0);
    chk("rst_y", y_o, 0);
    chk("rst_flags", {sof_o, eol_o, eof_o}, 0);

    // One full frame back-to-back.
    for (int i = 0; i < 12; i++) px(1'b1, 8'(i), 1'b1, 1'b0);
    chk("frame_done", frame_count_o, 1);
    chk("last_eof", {data_o, eof_o}, {8'h0B, 1'b1});
    px(1'b0, 8'h00, 1'b1, 1'b0);

    // Backpressure after the second pixel is registered.
    px(1'b1, 8'h00, 1'b1, 1'b0);
    px(1'b1, 8'h01, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      px(1'b1, 8'h02, 1'b0, 1'b0);
      chk("stall_data", data_o, 8'h01);
      chk("stall_x", x_o, 1);
      chk("stall_ready", ready_o, 0);
    end
    px(1'b1, 8'h02, 1'b1, 1'b0);
    px(1'b1, 8'h03, 1'b1, 1'b0);
    px(1'b0, 8'h00, 1'b1, 1'b0);

    // Bubbles.
    for (int i = 0; i < 8; i++) px(i % 2 == 0, 8'(8'h10 + i), 1'b1, 1'b0);

    // Resync on the 6th pixel.
    for (int i = 0; i < 8; i++) begin
      fc_before = fc;
      px(1'b1, 8'(8'h20 + i), 1'b1, i == 5);
      if (i == 5) begin
        chk("resync_xy", {x_o, y_o, sof_o}, {2'd0, 2'd0, 1'b1});
        chk("resync_fc", frame_count_o, fc_before);
      end
      if (i == 6) chk("resync_next", {x_o, y_o}, {2'd1, 2'd0});
    end
    px(1'b0, 8'h00, 1'b1, 1'b0);

    // Reset mid-frame with a stalled output.
    px(1'b1, 8'h40, 1'b1, 1'b0);
    px(1'b1, 8'h41, 1'b0, 1'b0);
    reset_i = 1'b1;
    valid_i = 1'b1;
    ready_i = 1'b0;
    cycle();
    chk("mid_rst_valid", valid_o, 0);
    chk("mid_rst_fc", frame_count_o, 0);
    px(1'b1, 8'h42, 1'b1, 1'b0);
    chk("post_rst_pix", {data_o, x_o, y_o, sof_o}, {8'h42, 2'd0, 2'd0, 1'b1});

    // Five frames to wrap the 2-bit frame counter.
    do_reset();
    for (int f = 0; f < 5; f++) begin
      for (int i = 0; i < 12; i++) px(1'b1, 8'(f * 16 + i), 1'b1, 1'b0);
      chk("fc_seq", frame_count_o, fseq[f]);
    end

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      px($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) != 0,
         $urandom_range(0, 19) == 0);
    end
    for (int i = 0; i < 3; i++) px(1'b0, 8'h00, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
